// File: rtl/dac_serializer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dac_serializer_pkg : FSM encoding, defaults and DAC frame constants
// Rev 1.0
// ----------------------------------------------------------------------------
package dac_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_CLK_DIV = 2;
  localparam int DEF_CS_GAP  = 2;

  // Frame constants shared with the other serial output stages
  localparam int DAC_LOAD_CYCLES = 1;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int dac_frame_cycles(input int width, input int clk_div,
                                          input int cs_gap);
    return DAC_LOAD_CYCLES + 2 * clk_div * width + cs_gap;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dac_serializer_sclk_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dac_serializer_sclk_gen : divided serial clock with rise/fall strobes
// Rev 1.0
// ----------------------------------------------------------------------------
module dac_serializer_sclk_gen
  import dac_serializer_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_sclk,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = cnt_width(CLK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          term;

  // Strobes flag the edge on which sclk_q is about to toggle, so the
  // consumer updates its data on the very same clock edge.
  always_comb begin
    term   = (cnt_q == CW'(CLK_DIV - 1));
    cnt_d  = '0;
    sclk_d = 1'b0;
    if (i_en) begin
      sclk_d = sclk_q;
      if (term) begin
        sclk_d = ~sclk_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    o_rise = i_en && term && !sclk_q;
    o_fall = i_en && term && sclk_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign o_sclk = sclk_q;

endmodule
`default_nettype wire

// File: rtl/dac_serializer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dac_serializer : buffered MSB-first SPI-style serializer for an audio DAC
// Rev 1.0
// ----------------------------------------------------------------------------
module dac_serializer
  import dac_serializer_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int CS_GAP  = DEF_CS_GAP
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_sclk,
  output logic             o_sdata,
  output logic             o_cs_n,
  output logic             o_busy
);

  localparam int BW = cnt_width(WIDTH);
  localparam int GW = cnt_width(CS_GAP);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  hold_q, hold_d;
  logic              full_q, full_d;
  logic [WIDTH-1:0]  sreg_q, sreg_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              last_q, last_d;
  logic              cs_n_q, cs_n_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;

  logic              sclk_en;
  logic              sclk_rise;
  logic              sclk_fall;
  logic              accept;

  assign sclk_en = (state_q == ST_SHIFT);

  dac_serializer_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (sclk_en),
    .o_sclk (o_sclk),
    .o_rise (sclk_rise),
    .o_fall (sclk_fall)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    full_d  = full_q;
    sreg_d  = sreg_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    last_d  = last_q;
    cs_n_d  = cs_n_q;
    accept  = i_valid && ready_q;

    case (state_q)
      ST_IDLE: begin
        if (full_q) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        sreg_d  = hold_q;
        full_d  = 1'b0;
        cs_n_d  = 1'b0;
        bit_d   = '0;
        gap_d   = '0;
        last_d  = 1'b0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (sclk_rise && (bit_q == BW'(WIDTH - 1))) last_d = 1'b1;
        if (sclk_fall) begin
          if (last_q) begin
            // Clearing the shift register parks the data line low in the gap
            sreg_d  = '0;
            cs_n_d  = 1'b1;
            gap_d   = '0;
            state_d = ST_GAP;
          end else begin
            sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
            bit_d  = bit_q + 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GW'(CS_GAP - 1)) begin
          state_d = full_q ? ST_LOAD : ST_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new sample takes priority over the LOAD that empties the buffer
    if (accept) begin
      hold_d = i_data;
      full_d = 1'b1;
    end

    // Ready is also offered in LOAD, letting a new sample land as the old one leaves
    ready_d = !full_d || (state_d == ST_LOAD);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      full_q  <= 1'b0;
      sreg_q  <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      last_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      sreg_q  <= sreg_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      last_q  <= last_d;
      cs_n_q  <= cs_n_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign o_sdata = sreg_q[WIDTH-1];
  assign o_cs_n  = cs_n_q;
  assign o_ready = ready_q;
  assign o_busy  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_dac_serializer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dac_serializer : scoreboard bench, default and fast-divider instances
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_dac_serializer;

  localparam int W = 16;

  function automatic int cd_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction
  function automatic int gp_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  logic            clk = 1'b0;
  logic [1:0]      rst = 2'b00;
  logic [1:0]      valid = 2'b00;
  logic [W-1:0]    data_a [2];
  wire  [1:0]      ready, sclk, sdata, cs_n, busy;

  int              checks = 0;
  int              failures = 0;
  int              cur = 0;
  logic [W-1:0]    exp_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dac_serializer #(
      .WIDTH   (W),
      .CLK_DIV (cd_of(g)),
      .CS_GAP  (gp_of(g))
    ) u_dut (
      .i_clk   (clk),
      .i_rst   (rst[g]),
      .i_data  (data_a[g]),
      .i_valid (valid[g]),
      .o_ready (ready[g]),
      .o_sclk  (sclk[g]),
      .o_sdata (sdata[g]),
      .o_cs_n  (cs_n[g]),
      .o_busy  (busy[g])
    );
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL dut%0d %s: got 0x%0h, expected 0x%0h", cur, name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    failures++;
    $display("FAIL dut%0d %s: wait expired, expected event", cur, name);
  endtask

  // ---------------- monitor / scoreboard ----------------
  int   n_s = 0, n_fall = 0, n_tog = 0, n_csrise = 0, rises = 0, m_ok = 0;
  logic p_cs = 1'b1, p_sclk = 1'b0, p_sdata = 1'b0, p_busy = 1'b0;
  bit   in_frame = 0, have_prev = 0, busy_dropped = 1;
  logic [W-1:0] word = '0;

  always @(negedge clk) begin : monitor
    n_s++;
    if (rst[cur]) begin
      p_cs = 1'b1; p_sclk = 1'b0; p_sdata = 1'b0; p_busy = 1'b0;
      in_frame = 0; have_prev = 0; busy_dropped = 1; rises = 0;
      exp_q.delete();
    end else begin
      if (sdata[cur] != p_sdata) begin
        m_ok = ((p_sclk && !sclk[cur]) || (cs_n[cur] != p_cs)) ? 1 : 0;
        check("sdata_changes_only_on_sclk_fall", m_ok, 1);
      end
      if (!cs_n[cur] && p_cs) begin
        if (have_prev && !busy_dropped)
          check("frame_period", n_s - n_fall, 1 + 2 * cd_of(cur) * W + gp_of(cur));
        n_fall = n_s; n_tog = n_s; rises = 0; word = '0;
        in_frame = 1; have_prev = 1; busy_dropped = 0;
      end
      if (in_frame && (sclk[cur] != p_sclk)) begin
        check("sclk_half_period", n_s - n_tog, cd_of(cur));
        n_tog = n_s;
      end
      if (in_frame && sclk[cur] && !p_sclk) begin
        word = {word[W-2:0], sdata[cur]};
        rises++;
      end
      if (cs_n[cur] && !p_cs) begin
        in_frame = 0;
        check("cs_low_cycles", n_s - n_fall, 2 * cd_of(cur) * W);
        check("sclk_rise_count", rises, W);
        check("sclk_idle_low", int'(sclk[cur]), 0);
        check("sdata_idle_low", int'(sdata[cur]), 0);
        if (exp_q.size() == 0) fail_timeout("unexpected_frame");
        else check("frame_data", int'(word), int'(exp_q.pop_front()));
        n_csrise = n_s;
      end
      if (!busy[cur] && p_busy) check("busy_fall_after_gap", n_s - n_csrise, gp_of(cur));
      if (!busy[cur]) busy_dropped = 1;
      p_cs = cs_n[cur]; p_sclk = sclk[cur]; p_sdata = sdata[cur]; p_busy = busy[cur];
    end
  end

  // ---------------- stimulus ----------------
  task automatic check_reset_outputs();
    check("rst_cs_n", int'(cs_n[cur]), 1);
    check("rst_sclk", int'(sclk[cur]), 0);
    check("rst_sdata", int'(sdata[cur]), 0);
    check("rst_ready", int'(ready[cur]), 1);
    check("rst_busy", int'(busy[cur]), 0);
  endtask

  task automatic send(input logic [W-1:0] v);
    int n = 0;
    @(negedge clk);
    data_a[cur] = v;
    valid[cur]  = 1'b1;
    while (!ready[cur] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!ready[cur]) begin
      fail_timeout("accept");
      valid[cur] = 1'b0;
    end else begin
      exp_q.push_back(v);
      @(posedge clk);
      #1 check("ready_low_after_accept", int'(ready[cur]), 0);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    valid[cur] = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || busy[cur]) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) fail_timeout("drain");
  endtask

  task automatic run_scenario();
    int n;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst[cur] = 1'b0;

    send(16'hA5C3); idle(); wait_idle();

    // back-to-back pair, then a third sample held off by the full buffer
    send(16'h0001); send(16'hFFFF); send(16'h1234); idle(); wait_idle();

    for (int i = 0; i < 6; i++) begin
      send(16'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        idle();
        repeat ($urandom_range(0, 150)) @(negedge clk);
      end
    end
    idle(); wait_idle();

    // abandon a frame after its 7th sclk rise
    send(16'($urandom)); idle();
    n = 0;
    while (!(in_frame && rises >= 7) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) fail_timeout("seventh_rise");
    #2 rst[cur] = 1'b1;
    #1 check_reset_outputs();
    @(negedge clk); @(negedge clk);
    rst[cur] = 1'b0;

    send(16'h8000); idle(); wait_idle();
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin : main
    data_a[0] = '0;
    data_a[1] = '0;
    #1 rst = 2'b11;
    cur = 0;
    run_scenario();
    @(negedge clk);
    rst[0] = 1'b1;
    cur = 1;
    run_scenario();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/dac_serializer.md
# dac_serializer

Output stage of the synth. Takes the 16-bit unsigned samples produced by the amplitude stage and shifts them MSB-first to an external SPI-style audio DAC. It generates a chip select (o_cs_n), a serial clock (o_sclk) and a data line (o_sdata). A one-entry holding buffer with a valid/ready handshake decouples the sample producer from the serial frame timing.

## Interface
Parameters:
- WIDTH, 16, sample width in bits; also the number of bits per frame.
- CLK_DIV, 2, i_clk cycles per o_sclk half-period; legal range ≥1.
- CS_GAP, 2, i_clk cycles that o_cs_n stays high between frames; legal range ≥1.

Ports:
- i_clk  in  1  system clock (50 MHz).
- i_rst  in  1  asynchronous, active-high reset.
- i_data  in  WIDTH  unsigned sample from the amplitude stage.
- i_valid  in  1  i_data is valid; the producer holds i_data and i_valid until accepted.
- o_ready  out  1  holding buffer is empty.
- o_sclk  out  1  DAC serial clock; idles low; the DAC samples on the rising edge.
- o_sdata  out  1  serial data, MSB first; changes only while o_sclk is low.
- o_cs_n  out  1  active-low frame select.
- o_busy  out  1  high whenever the state is not IDLE.

## Operation
- **Accept rule:** a sample is accepted at a clock edge where i_valid && o_ready. It is copied into the buffer (buf, buf_full). At the next edge o_ready goes low.
- **IDLE:** if buf_full, go to LOAD. Otherwise stay.
- **LOAD (1 cycle):**
  - shift register <= buf, which clears buf_full.
  - o_cs_n <= 0, o_sdata <= buf[WIDTH-1], bit counter <= 0, divider <= 0.
  - Go to SHIFT.
- **SHIFT:**
  - The divider counts 0..CLK_DIV-1. On terminal count, o_sclk toggles.
  - On a falling toggle, the shift register shifts left, o_sdata takes the new MSB, and the bit counter increments.
  - After the falling toggle that follows the WIDTH-th rising edge: o_cs_n <= 1, o_sdata <= 0, go to GAP.
- **GAP:** o_cs_n stays high for CS_GAP cycles. Then go to LOAD if buf_full, otherwise IDLE.
- **Buffer during a frame:** the buffer can accept one new sample while a frame is in SHIFT or GAP, so back-to-back frames need no IDLE cycle.
- **Simultaneous load and accept:** if LOAD clears buf_full on the same edge that a new sample is accepted, the accept wins. buf_full stays 1 and the new data is stored.
- **Full buffer:** i_valid while o_ready=0 has no effect. The producer must hold.
- **Reset values (async, any state):**
  - Outputs: o_cs_n=1, o_sclk=0, o_sdata=0, o_ready=1, o_busy=0.
  - Internal: state=IDLE, buf_full=0, counters=0.
  - A partial frame in flight is abandoned and never resumed.

## Timing
- **Latency:** accept at edge t gives LOAD at t+1 (when IDLE) and o_cs_n low after t+2.
- **Frame length:** LOAD (1) + 2·CLK_DIV·WIDTH SHIFT cycles + CS_GAP. With defaults this is 1+64+2 = 67 cycles (1.34 µs, 746 kHz maximum sample rate).
- **Bit timing:**
  - o_sdata is stable for CLK_DIV cycles before and CLK_DIV cycles after each rising edge of o_sclk.
  - The first rising edge of o_sclk occurs CLK_DIV cycles after o_cs_n falls.
- **Registered outputs:** all outputs are registered, with no combinational path from any input to any output.
- **Sample rate contract:** sustained throughput is one sample per frame length. Upstream must not present new samples faster than this, or it will see o_ready backpressure.

## Structure
- **Shared defines** go in shared header synth_defs.vh:
  - state encoding (IDLE, LOAD, SHIFT, GAP, 2 bits);
  - default WIDTH, CLK_DIV and CS_GAP;
  - DAC frame constants reused by other output stages.
- **Sub-module sclk_gen:**
  - Contains the divider counter and the o_sclk register.
  - Enabled by the FSM; emits one-cycle rise and fall pulses.
  - Resets to o_sclk=0, count=0.
- **Top level:** the FSM, holding buffer, shift register and bit counter stay in dac_serializer.

## Test plan
- **Single sample:** reset, then present i_data=16'hA5C3 with i_valid for one accepted cycle.
  - o_cs_n is low for exactly 64 cycles.
  - 16 rising edges of o_sclk sample the bits 1010_0101_1100_0011.
  - o_cs_n goes high; o_busy is low 67 cycles after LOAD.
- **Back-to-back:** hold i_valid high with 16'h0001, then 16'hFFFF.
  - The second sample is accepted during the first frame's SHIFT.
  - GAP lasts exactly 2 cycles, then the next LOAD, with no IDLE between frames.
- **Backpressure:** with a frame in progress and the buffer full, drive a third sample 16'h1234.
  - o_ready stays 0 and the value is not captured until LOAD empties the buffer.
  - The accept then occurs and 16'h1234 is shifted out later, intact.
- **Simultaneous event:** align a new accept with the LOAD edge.
  - buf_full=1 after that edge.
  - Both samples are shifted out in order.
- **Reset mid-frame:** assert i_rst after the 7th rising edge of o_sclk.
  - All outputs go to reset values immediately (asynchronously), including o_cs_n=1 and o_sclk=0.
  - After release, a new sample 16'h8000 frames correctly.
- **Parameter sweep:** CLK_DIV=1, CS_GAP=1, WIDTH=16.
  - Frame length is 34 cycles.
  - Verify o_sdata setup and hold around each o_sclk rise.
